pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard and stall controller for a five-stage pipeline.
//
// Decides stage-register load enables, IF/ID flush and bubble insertion from
// the current hazards: data-memory freeze, taken branch in EX and load-use
// dependency between EX and ID. A memory access that stays stuck for TIMEOUT
// consecutive freeze cycles parks the controller in HALT until reset.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   memRead_EX, rd_EX          EX instruction is a load / its destination
//   rn_ID, rm_ID               ID instruction source registers
//   useRn_ID, useRm_ID         ID instruction actually reads rn / rm
//   branchTaken_EX             branch resolved taken in EX
//   mem_req_MEM, mem_ready     MEM stage access request / access complete
//   pc_en .. EX_MEM_en         stage-register load enables
//   IF_ID_flush                clear IF/ID to a NOP
//   ID_EX_bubble, MEM_WB_bubble  load zeroed control into ID/EX, MEM/WB
//   mem_timeout                sticky: memory never answered, pipeline halted
//   stall_cycles, flush_count  saturating performance counters
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead_EX,
    input  logic [4:0]  rd_EX,
    input  logic [4:0]  rn_ID,
    input  logic [4:0]  rm_ID,
    input  logic        useRn_ID,
    input  logic        useRm_ID,
    input  logic        branchTaken_EX,
    input  logic        mem_req_MEM,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        IF_ID_en,
    output logic        ID_EX_en,
    output logic        EX_MEM_en,
    output logic        IF_ID_flush,
    output logic        ID_EX_bubble,
    output logic        MEM_WB_bubble,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    // wait_cnt value on which a further freeze cycle trips the timeout
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] stall_q;
    logic [15:0] flush_q;
    logic        timeout_q;

    logic freeze;
    logic load_use;
    logic branch_flush;

    assign freeze = mem_req_MEM & ~mem_ready;

    // XZR (register 31) reads as zero, so a load targeting it creates no dependency
    assign load_use = memRead_EX && (rd_EX != 5'd31) &&
                      ((useRn_ID && (rn_ID == rd_EX)) ||
                       (useRm_ID && (rm_ID == rd_EX)));

    // Freeze outranks the branch; the branch is still held in EX and gets
    // applied in the first cycle the freeze lifts.
    assign branch_flush = (state_q != HALT) && !freeze && branchTaken_EX;

    always_comb begin
        pc_en         = 1'b1;
        IF_ID_en      = 1'b1;
        ID_EX_en      = 1'b1;
        EX_MEM_en     = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_bubble  = 1'b0;
        MEM_WB_bubble = 1'b0;
        if (state_q == HALT) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            ID_EX_bubble  = 1'b1;
            MEM_WB_bubble = 1'b1;
        end else if (freeze) begin
            // Everything up to EX/MEM holds; MEM/WB gets a bubble so the
            // stalled access is not written back twice.
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_en      = 1'b0;
            EX_MEM_en     = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (branchTaken_EX) begin
            IF_ID_flush   = 1'b1;
            ID_EX_bubble  = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            IF_ID_en      = 1'b0;
            ID_EX_bubble  = 1'b1;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            stall_q    <= 32'd0;
            flush_q    <= 16'd0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q != HALT) begin
                if (!pc_en && !(&stall_q))
                    stall_q <= stall_q + 32'd1;
                if (branch_flush && !(&flush_q))
                    flush_q <= flush_q + 16'd1;
            end
            case (state_q)
                RUN: begin
                    if (freeze) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= 8'd1;
                    end else begin
                        wait_cnt_q <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (!freeze) begin
                        state_q    <= RUN;
                        wait_cnt_q <= 8'd0;
                    end else if (wait_cnt_q == LAST_CNT) begin
                        state_q   <= HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                default: begin
                    // HALT is left only through reset
                    state_q <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        memRead_EX;
    logic [4:0]  rd_EX, rn_ID, rm_ID;
    logic        useRn_ID, useRm_ID, branchTaken_EX, mem_req_MEM, mem_ready;
    logic        pc_en, IF_ID_en, ID_EX_en, EX_MEM_en;
    logic        IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, mem_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .memRead_EX(memRead_EX), .rd_EX(rd_EX), .rn_ID(rn_ID), .rm_ID(rm_ID),
        .useRn_ID(useRn_ID), .useRm_ID(useRm_ID), .branchTaken_EX(branchTaken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready(mem_ready),
        .pc_en(pc_en), .IF_ID_en(IF_ID_en), .ID_EX_en(ID_EX_en), .EX_MEM_en(EX_MEM_en),
        .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
        .MEM_WB_bubble(MEM_WB_bubble), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, mem_timeout}
    localparam logic [7:0] O_DEF  = 8'b1111_0000;
    localparam logic [7:0] O_FRZ  = 8'b0000_0010;
    localparam logic [7:0] O_BR   = 8'b1111_1100;
    localparam logic [7:0] O_LU   = 8'b0011_0100;
    localparam logic [7:0] O_HALT = 8'b0000_0111;

    typedef struct {
        string      name;
        logic       mrd;
        logic [4:0] rd, rn, rm;
        logic       urn, urm, br, req, rdy;
        logic [7:0] exp_o;
        int         d_stall;
        int         d_flush;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [7:0] outs();
        return {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en,
                IF_ID_flush, ID_EX_bubble, MEM_WB_bubble, mem_timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic drive(input logic mrd, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic urn, input logic urm,
                         input logic br, input logic req, input logic rdy);
        memRead_EX = mrd; rd_EX = rd; rn_ID = rn; rm_ID = rm;
        useRn_ID = urn; useRm_ID = urm; branchTaken_EX = br;
        mem_req_MEM = req; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // one freeze cycle: check outputs mid-cycle, then advance past the edge
    task automatic freeze_cycle(input string name, input logic [7:0] exp_o);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk(name, {24'd0, outs()}, {24'd0, exp_o});
        @(posedge clk); #1;
    endtask

    int exp_stall;
    int exp_flush;

    initial begin
        vecs[0]  = '{"idle",          0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 0, 0};
        vecs[1]  = '{"lu_rn",         1, 5, 5, 0, 1, 0, 0, 0, 1, O_LU,  1, 0};
        vecs[2]  = '{"lu_xzr",        1, 31, 31, 31, 1, 1, 0, 0, 1, O_DEF, 0, 0};
        vecs[3]  = '{"lu_rm",         1, 7, 0, 7, 0, 1, 0, 0, 1, O_LU,  1, 0};
        vecs[4]  = '{"rm_unused",     1, 7, 0, 7, 0, 0, 0, 0, 1, O_DEF, 0, 0};
        vecs[5]  = '{"not_load",      0, 5, 5, 5, 1, 1, 0, 0, 1, O_DEF, 0, 0};
        vecs[6]  = '{"br_over_lu",    1, 5, 5, 0, 1, 0, 1, 0, 1, O_BR,  0, 1};
        vecs[7]  = '{"br_only",       0, 0, 0, 0, 0, 0, 1, 0, 1, O_BR,  0, 1};
        vecs[8]  = '{"req_ready",     0, 0, 0, 0, 0, 0, 0, 1, 1, O_DEF, 0, 0};
        vecs[9]  = '{"freeze",        1, 5, 5, 0, 1, 0, 0, 1, 0, O_FRZ, 1, 0};
        vecs[10] = '{"unfreeze",      0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF, 0, 0};
        vecs[11] = '{"freeze_br",     0, 0, 0, 0, 0, 0, 1, 1, 0, O_FRZ, 1, 0};
        vecs[12] = '{"br_after_frz",  0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR,  0, 1};
        vecs[13] = '{"lu_rm_noreq",   1, 9, 3, 9, 1, 1, 0, 0, 0, O_LU,  1, 0};

        idle();
        reset = 1'b1;
        #12;
        chk("reset_outs",  {24'd0, outs()}, {24'd0, O_DEF});
        chk("reset_stall", stall_cycles, 32'd0);
        chk("reset_flush", {16'd0, flush_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // table-driven single-cycle vectors with running counter expectations
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].mrd, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].urn,
                  vecs[i].urm, vecs[i].br, vecs[i].req, vecs[i].rdy);
            @(negedge clk);
            chk({vecs[i].name, "_outs"}, {24'd0, outs()}, {24'd0, vecs[i].exp_o});
            @(posedge clk); #1;
            exp_stall += vecs[i].d_stall;
            exp_flush += vecs[i].d_flush;
            chk({vecs[i].name, "_stall"}, stall_cycles, 32'(exp_stall));
            chk({vecs[i].name, "_flush"}, {16'd0, flush_count}, 32'(exp_flush));
        end

        // three freeze cycles then ready: no halt, three stalls
        idle();
        do_reset();
        for (int i = 0; i < 3; i++) freeze_cycle("frz3_outs", O_FRZ);
        idle();
        @(negedge clk);
        chk("frz3_release_outs", {24'd0, outs()}, {24'd0, O_DEF});
        @(posedge clk); #1;
        chk("frz3_stall", stall_cycles, 32'd3);
        chk("frz3_no_timeout", {31'd0, mem_timeout}, 32'd0);
        // a fresh freeze run must again tolerate three cycles (wait_cnt restarted)
        for (int i = 0; i < 3; i++) freeze_cycle("frz3b_outs", O_FRZ);
        chk("frz3b_no_timeout", {31'd0, mem_timeout}, 32'd0);
        idle();
        @(posedge clk); #1;

        // timeout: TIMEOUT=4 consecutive freeze cycles -> HALT
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("to_not_yet", {31'd0, mem_timeout}, 32'd0);
            freeze_cycle("to_frz_outs", O_FRZ);
        end
        chk("to_timeout", {31'd0, mem_timeout}, 32'd1);
        chk("to_stall", stall_cycles, 32'd4);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("halt_outs", {24'd0, outs()}, {24'd0, O_HALT});
            @(posedge clk); #1;
        end
        chk("halt_stall_frozen", stall_cycles, 32'd4);
        chk("halt_flush_frozen", {16'd0, flush_count}, 32'd0);
        // asynchronous reset clears HALT between clock edges
        idle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("halt_rst_timeout", {31'd0, mem_timeout}, 32'd0);
        chk("halt_rst_outs", {24'd0, outs()}, {24'd0, O_DEF});
        chk("halt_rst_stall", stall_cycles, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // reset pulse mid-MEM_WAIT, then RUN rules on the first edge
        for (int i = 0; i < 2; i++) freeze_cycle("mw_frz_outs", O_FRZ);
        chk("mw_stall", stall_cycles, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("mw_rst_stall", stall_cycles, 32'd0);
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("mw_rst_br_outs", {24'd0, outs()}, {24'd0, O_BR});
        @(posedge clk); #1;
        chk("mw_rst_flush", {16'd0, flush_count}, 32'd1);
        chk("mw_rst_stall2", stall_cycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
